dnn_pe_sequencer: RTL and testbench
===================================

# dnn_pe_sequencer

On-chip sequencer that drives the PE scratchpad load, compute and readout controls of the DNN accelerator core. Today the host bit-bangs these controls (selPE, sipo_en, sipo_en2, sp_din, sp_load, sp_load2, en, ps_load) from GPIO. This block takes over that job. It accepts a start command plus a serial operand stream, then issues the control sequence in the fixed, correct order: weights, data, compute, capture, drain. It sits between the host-facing interface logic and the accelerator core's control inputs.

## Interface
- WORD_W, 16: bits per scratchpad word (weight and data each)
- OUT_W, 16: bits shifted out of the PISO per result
- CNT_W, 8: width of the compute-cycle count
- clk  in  1  single clock for all state
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- cfg_pe  in  2  PE select for this command
- cfg_compute  in  CNT_W  number of compute-enable cycles (0 is treated as 1)
- s_valid  in  1  serial operand bit valid
- s_bit  in  1  serial operand bit (WORD_W weight bits first, then WORD_W data bits, LSB first)
- s_ready  out  1  operand bit accepted when s_valid & s_ready
- selPE  out  2  PE select to core
- sipo_en, sipo_en2  out  1 each  weight / data SIPO shift enables
- sp_din  out  1  serial bit to SIPOs
- sp_load, sp_load2  out  1 each  weight / data scratchpad commit strobes
- en  out  1  PE compute enable
- ps_load  out  1  PISO parallel capture strobe
- ps_shift  out  1  PISO shift enable
- ps_out  in  1  PISO serial output from core
- r_valid, r_bit  out  1 each  result bit stream to host
- r_ready  in  1  host accepts result bit
- busy, done  out  1 each  command in progress / one-cycle completion pulse

## Operation
- The FSM has nine states: IDLE, LOAD_WT, COMMIT_WT, LOAD_DIN, COMMIT_DIN, COMPUTE, CAPTURE, DRAIN, DONE.
- **IDLE**
  - busy=0.
  - On start=1: latch cfg_pe into selPE and latch max(cfg_compute,1) into the compute counter.
  - Clear the bit counter and go to LOAD_WT.
- **LOAD_WT**
  - s_ready=1.
  - On each s_valid: sipo_en=1, sp_din=s_bit (combinational), bit counter +1.
  - After the WORD_W-th accepted bit, go to COMMIT_WT.
  - A cycle with s_valid=0 stalls: sipo_en=0, no count.
- **COMMIT_WT:** sp_load=1 for exactly one cycle, clear the bit counter, go to LOAD_DIN.
- **LOAD_DIN:** same as LOAD_WT, except it drives sipo_en2 instead of sipo_en. It exits to COMMIT_DIN.
- **COMMIT_DIN:** sp_load2=1 for one cycle, go to COMPUTE.
- **COMPUTE:** en=1 for exactly N cycles (N = the latched count), then go to CAPTURE.
- **CAPTURE:** ps_load=1 for one cycle, clear the bit counter, go to DRAIN.
- **DRAIN**
  - r_valid=1, r_bit=ps_out.
  - On r_ready: ps_shift=1, bit counter +1.
  - After OUT_W transfers, go to DONE.
- **DONE:** done=1 for one cycle, go to IDLE.
- **Outputs by state**
  - busy=1 in every state except IDLE.
  - s_ready is 1 only in the LOAD states.
  - r_valid is 1 only in DRAIN.
  - All strobes not listed for a state are 0.
- selPE holds the last latched value until the next accepted start.
- **Abort:** abort=1 in any state forces IDLE at the next edge. No done pulse is issued and the partially loaded scratchpads are not committed. abort takes priority over start.
- start while busy=1 is ignored; it is not queued.
- The bit counter is $clog2(max(WORD_W,OUT_W)+1) bits wide. It never wraps, because every state exits on its terminal count.

## Timing
- **Reset:** reset_n=0 at a clock edge forces the FSM to IDLE and clears both counters and selPE.
  - All outputs are 0 after reset: selPE=2'b00, every strobe 0, s_ready=0, r_valid=0, busy=0, done=0.
  - Reset mid-operation behaves the same as abort.
- All strobes are pure decodes of the registered state plus the handshake inputs. There are no output flops, so the core sees each strobe in the same cycle the FSM occupies the state.
- **Latency with s_valid and r_ready held high** (start sampled in cycle 0):
  - LOAD_WT: cycles 1..WORD_W.
  - COMMIT_WT: WORD_W+1.
  - LOAD_DIN: WORD_W+2 .. 2·WORD_W+1.
  - COMMIT_DIN: 2·WORD_W+2.
  - COMPUTE: 2·WORD_W+3 .. 2·WORD_W+2+N.
  - CAPTURE: 2·WORD_W+3+N.
  - DRAIN: OUT_W cycles.
  - done is asserted at cycle 2·WORD_W+OUT_W+N+4.
- Every stall cycle (s_valid=0 or r_ready=0) adds exactly one cycle.
- A new start is accepted earliest in the cycle after done (back-to-back commands).

## Test plan
- **Basic command:** reset, start, cfg_pe=2, cfg_compute=4, s_valid=1 with stream 0xA5C3 (weight) then 0x0F0F (data), r_ready=1.
  - sipo_en high cycles 1–16; sp_load at 17; sipo_en2 at 18–33; sp_load2 at 34; en at 35–38; ps_load at 39; r_valid at 40–55; done at 56.
  - selPE=2 throughout; sp_din matches the stream bit order.
- **Backpressure:** same command with s_valid low every third cycle and r_ready low for 5 cycles in DRAIN.
  - Exactly 16 sipo_en pulses, 16 sipo_en2 pulses and 16 ps_shift pulses.
  - done arrives late by exactly the number of stall cycles.
- **Zero compute:** cfg_compute=0 → en asserted for exactly 1 cycle.
- **Abort:** abort during LOAD_DIN at bit 7.
  - Next cycle busy=0; sp_load2 and done never pulse.
  - A subsequent start runs to completion normally.
- **Start while busy:** a start pulse mid-COMPUTE with cfg_pe=1 is ignored; selPE stays 2 and only one done pulse is issued.
- **Reset mid-DRAIN:** reset_n=0 for 1 cycle → all outputs 0 and selPE=0 the next cycle; back-to-back start after done is accepted in the following cycle.

Source files
------------

// File: rtl/dnn_pe_sequencer.sv
// dnn_pe_sequencer: issues PE scratchpad load, compute, capture and readout controls
// in a fixed weights -> data -> compute -> capture -> drain order from a serial operand stream.
module dnn_pe_sequencer #(
    parameter int WORD_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       cfg_pe,
    input  logic [CNT_W-1:0] cfg_compute,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic [1:0]       selPE,
    output logic             sipo_en,
    output logic             sipo_en2,
    output logic             sp_din,
    output logic             sp_load,
    output logic             sp_load2,
    output logic             en,
    output logic             ps_load,
    output logic             ps_shift,
    input  logic             ps_out,
    output logic             r_valid,
    output logic             r_bit,
    input  logic             r_ready,
    output logic             busy,
    output logic             done
);

    localparam int MAX_W  = (WORD_W > OUT_W) ? WORD_W : OUT_W;
    localparam int BIT_CW = $clog2(MAX_W + 1);
    localparam logic [BIT_CW-1:0] WORD_LAST = BIT_CW'(WORD_W - 1);
    localparam logic [BIT_CW-1:0] OUT_LAST  = BIT_CW'(OUT_W - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_WT,
        COMMIT_WT,
        LOAD_DIN,
        COMMIT_DIN,
        COMPUTE,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [BIT_CW-1:0] bit_cnt;
    logic [CNT_W-1:0]  comp_cnt;

    // Abort leaves selPE alone; only reset or a new start changes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            comp_cnt <= '0;
            selPE    <= 2'b00;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        selPE    <= cfg_pe;
                        comp_cnt <= (cfg_compute == '0) ? CNT_W'(1) : cfg_compute;
                        bit_cnt  <= '0;
                        state    <= LOAD_WT;
                    end
                end
                LOAD_WT: begin
                    if (s_valid) begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                        if (bit_cnt == WORD_LAST) state <= COMMIT_WT;
                    end
                end
                COMMIT_WT: begin
                    bit_cnt <= '0;
                    state   <= LOAD_DIN;
                end
                LOAD_DIN: begin
                    if (s_valid) begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                        if (bit_cnt == WORD_LAST) state <= COMMIT_DIN;
                    end
                end
                COMMIT_DIN: state <= COMPUTE;
                COMPUTE: begin
                    if (comp_cnt <= CNT_W'(1)) state <= CAPTURE;
                    else comp_cnt <= comp_cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    bit_cnt <= '0;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    if (r_ready) begin
                        bit_cnt <= bit_cnt + BIT_CW'(1);
                        if (bit_cnt == OUT_LAST) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state so the core sees them in the same cycle.
    assign s_ready  = (state == LOAD_WT) || (state == LOAD_DIN);
    assign sipo_en  = (state == LOAD_WT) && s_valid;
    assign sipo_en2 = (state == LOAD_DIN) && s_valid;
    assign sp_din   = s_ready && s_valid && s_bit;
    assign sp_load  = (state == COMMIT_WT);
    assign sp_load2 = (state == COMMIT_DIN);
    assign en       = (state == COMPUTE);
    assign ps_load  = (state == CAPTURE);
    assign r_valid  = (state == DRAIN);
    assign r_bit    = r_valid && ps_out;
    assign ps_shift = r_valid && r_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_dnn_pe_sequencer.sv
// tb_dnn_pe_sequencer: scoreboard bench; stimulus pushes timed expected strobe events,
// a negedge monitor pops and compares every strobe the sequencer raises.
module tb_dnn_pe_sequencer;

    localparam int K_SIPO   = 0;
    localparam int K_SIPO2  = 1;
    localparam int K_LOAD   = 2;
    localparam int K_LOAD2  = 3;
    localparam int K_EN     = 4;
    localparam int K_PSLOAD = 5;
    localparam int K_SHIFT  = 6;
    localparam int K_DONE   = 7;
    localparam logic [15:0] RESULT = 16'h6D3B;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [1:0] cfg_pe;
    logic [7:0] cfg_compute;
    logic       s_valid;
    logic       s_bit;
    logic       s_ready;
    logic [1:0] sel_pe;
    logic       sipo_en;
    logic       sipo_en2;
    logic       sp_din;
    logic       sp_load;
    logic       sp_load2;
    logic       en;
    logic       ps_load;
    logic       ps_shift;
    logic       ps_out;
    logic       r_valid;
    logic       r_bit;
    logic       r_ready;
    logic       busy;
    logic       done;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];

    logic [15:0] piso = 16'h0000;
    logic        ld_p = 1'b0;
    logic        sh_p = 1'b0;
    logic [14:0] all_outs;

    dnn_pe_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .cfg_pe      (cfg_pe),
        .cfg_compute (cfg_compute),
        .s_valid     (s_valid),
        .s_bit       (s_bit),
        .s_ready     (s_ready),
        .selPE       (sel_pe),
        .sipo_en     (sipo_en),
        .sipo_en2    (sipo_en2),
        .sp_din      (sp_din),
        .sp_load     (sp_load),
        .sp_load2    (sp_load2),
        .en          (en),
        .ps_load     (ps_load),
        .ps_shift    (ps_shift),
        .ps_out      (ps_out),
        .r_valid     (r_valid),
        .r_bit       (r_bit),
        .r_ready     (r_ready),
        .busy        (busy),
        .done        (done)
    );

    assign all_outs = {sel_pe, sipo_en, sipo_en2, sp_din, sp_load, sp_load2, en,
                       ps_load, ps_shift, r_valid, r_bit, s_ready, busy, done};
    assign ps_out = piso[0];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the core's PISO: strobes seen mid-cycle take effect at the next edge.
    always @(negedge clk) begin
        ld_p = ps_load;
        sh_p = ps_shift;
    end

    always @(posedge clk) begin
        if (ld_p) piso <= RESULT;
        else if (sh_p) piso <= {1'b0, piso[15:1]};
    end

    function automatic string kindName(input int k);
        case (k)
            K_SIPO:   return "sipo_en";
            K_SIPO2:  return "sipo_en2";
            K_LOAD:   return "sp_load";
            K_LOAD2:  return "sp_load2";
            K_EN:     return "en";
            K_PSLOAD: return "ps_load";
            K_SHIFT:  return "ps_shift";
            K_DONE:   return "done";
            default:  return "none";
        endcase
    endfunction

    function automatic void pushExpected(input int kind, input int at, input logic [2:0] data);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        logic [7:0] strobes;
        logic [2:0] act;
        exp_t       e;
        if (mon_en) begin
            strobes = {done, ps_shift, ps_load, en, sp_load2, sp_load, sipo_en2, sipo_en};
            for (int k = 0; k < 8; k++) begin
                if (strobes[k]) begin
                    if (k <= K_SIPO2) act = {sel_pe, sp_din};
                    else if (k == K_SHIFT) act = {sel_pe, r_bit & r_valid};
                    else act = {sel_pe, 1'b0};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_%s cyc=%0d got_data=%0h required=no_event",
                                 kindName(k), cyc, act);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.cyc != cyc || e.data != act) begin
                            failures++;
                            $display("[TB] FAIL event_%s got kind=%s cyc=%0d data=%0h required kind=%s cyc=%0d data=%0h",
                                     kindName(e.kind), kindName(k), cyc, act,
                                     kindName(e.kind), e.cyc, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s got=%0h required=%0h", name, actual, required);
        end
    endtask

    // Builds the cycle schedule for one command, queues its expected strobes, then drives it.
    // Called and returns just after a rising edge; offset 0 is the cycle start is held high.
    task automatic applyStimulus(input logic [1:0] pe, input int comp, input logic [15:0] wt,
                                 input logic [15:0] din, input int smod, input int r_stall,
                                 input int abort_bit, input int reset_bit, input bit busy_start);
        logic        sv [0:255];
        logic        sb [0:255];
        logic        rr [0:255];
        logic        ab [0:255];
        logic        rs [0:255];
        logic        bs [0:255];
        logic [15:0] res;
        int          t;
        int          cut;
        int          last;
        int          n;
        int          base;
        res  = RESULT;
        base = cyc;
        cut  = -1;
        t    = 1;
        for (int i = 0; i < 256; i++) begin
            sv[i] = 1'b0; sb[i] = 1'b0; rr[i] = 1'b1;
            ab[i] = 1'b0; rs[i] = 1'b0; bs[i] = 1'b0;
        end
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 16; i++) begin
                while (smod != 0 && t % smod == 0) t++;
                if (ph == 1 && i == abort_bit && cut < 0) begin
                    cut   = t;
                    ab[t] = 1'b1;
                    t++;
                end
                sv[t] = 1'b1;
                sb[t] = (ph == 1) ? din[i] : wt[i];
                if (cut < 0) pushExpected((ph == 1) ? K_SIPO2 : K_SIPO, base + t, {pe, sb[t]});
                t++;
            end
            if (cut < 0) pushExpected((ph == 1) ? K_LOAD2 : K_LOAD, base + t, {pe, 1'b0});
            t++;
        end
        n = (comp == 0) ? 1 : comp;
        for (int i = 0; i < n; i++) begin
            if (busy_start && i == 1) bs[t] = 1'b1;
            if (cut < 0) pushExpected(K_EN, base + t, {pe, 1'b0});
            t++;
        end
        if (cut < 0) pushExpected(K_PSLOAD, base + t, {pe, 1'b0});
        t++;
        for (int i = 0; i < r_stall; i++) begin
            rr[t] = 1'b0;
            t++;
        end
        for (int i = 0; i < 16; i++) begin
            if (i == reset_bit && cut < 0) begin
                cut   = t;
                rs[t] = 1'b1;
            end
            if (cut < 0 || t <= cut) pushExpected(K_SHIFT, base + t, {pe, res[i]});
            t++;
        end
        if (cut < 0) pushExpected(K_DONE, base + t, {pe, 1'b0});
        last = (cut < 0) ? t : cut;

        for (int off = 0; off <= last; off++) begin
            start       = (off == 0) || bs[off];
            cfg_pe      = bs[off] ? 2'd1 : pe;
            cfg_compute = 8'(comp);
            s_valid     = sv[off];
            s_bit       = sb[off];
            r_ready     = rr[off];
            abort       = ab[off];
            reset_n     = !rs[off];
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        abort   = 1'b0;
        reset_n = 1'b1;
        r_ready = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_pe      = 2'd0;
        cfg_compute = 8'd0;
        s_valid     = 1'b0;
        s_bit       = 1'b0;
        r_ready     = 1'b1;
        idleCycles(3);
        reset_n = 1'b1;
        checkOutput("reset_outputs", 32'(all_outs), 32'd0);
        mon_en = 1'b1;

        $display("[TB] basic command");
        applyStimulus(2'd2, 4, 16'hA5C3, 16'h0F0F, 0, 0, -1, -1, 1'b0);
        checkOutput("basic_busy_after_done", 32'(busy), 32'd0);
        checkOutput("basic_selpe_held", 32'(sel_pe), 32'd2);
        checkOutput("basic_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idleCycles(2);

        $display("[TB] backpressure");
        applyStimulus(2'd2, 4, 16'hA5C3, 16'h0F0F, 3, 5, -1, -1, 1'b0);
        checkOutput("backpressure_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idleCycles(2);

        $display("[TB] zero compute");
        applyStimulus(2'd1, 0, 16'h1234, 16'h8001, 0, 0, -1, -1, 1'b0);
        checkOutput("zero_compute_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idleCycles(2);

        $display("[TB] abort in LOAD_DIN");
        applyStimulus(2'd3, 2, 16'hFFFF, 16'h00FF, 0, 0, 7, -1, 1'b0);
        checkOutput("abort_busy_next_cycle", 32'(busy), 32'd0);
        checkOutput("abort_selpe_held", 32'(sel_pe), 32'd3);
        idleCycles(4);
        checkOutput("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        applyStimulus(2'd0, 2, 16'h5A5A, 16'hC001, 0, 0, -1, -1, 1'b0);
        checkOutput("after_abort_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idleCycles(2);

        $display("[TB] start while busy");
        applyStimulus(2'd2, 3, 16'h00F0, 16'h0F00, 0, 0, -1, -1, 1'b1);
        checkOutput("busy_start_selpe", 32'(sel_pe), 32'd2);
        idleCycles(3);
        checkOutput("busy_start_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        $display("[TB] reset mid-drain");
        applyStimulus(2'd2, 2, 16'hAAAA, 16'h5555, 0, 2, -1, 5, 1'b0);
        checkOutput("reset_drain_outputs", 32'(all_outs), 32'd0);
        idleCycles(3);
        checkOutput("reset_drain_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        $display("[TB] back-to-back commands");
        applyStimulus(2'd1, 1, 16'h8421, 16'h1248, 0, 0, -1, -1, 1'b0);
        applyStimulus(2'd3, 2, 16'hF00D, 16'hBEEF, 0, 0, -1, -1, 1'b0);
        checkOutput("b2b_selpe", 32'(sel_pe), 32'd3);
        idleCycles(2);
        checkOutput("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
